// File: rtl/lpfull_coeff_sequencer.sv
// Runtime coefficient sequencer for the 8-lane half-band lowpass.
// Software fills a shadow bank through a valid/ready port; a commit copies
// the bank (upshifted) onto the live DSP coefficient bus, then holds the
// filter in reset and blanks its output valid while the pipeline flushes.
module lpfull_coeff_sequencer #(
   parameter int unsigned NTAPS         = 8,
   parameter int unsigned COEFF_BITS    = 18,
   parameter int unsigned COEFF_UPSHIFT = 3,
   parameter int unsigned FLUSH_CYCLES  = 12
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_valid_i,
   output logic                          wr_ready_o,
   input  logic [$clog2(NTAPS)-1:0]      wr_addr_i,
   input  logic [COEFF_BITS-1:0]         wr_data_i,
   input  logic                          commit_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [NTAPS*COEFF_BITS-1:0]   coeff_o,
   output logic                          filt_rst_o,
   output logic                          out_valid_o
);

   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SWAP,
      FLUSH
   } state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic signed [COEFF_BITS-1:0]  shadow_q [NTAPS];
   logic                          dirty_q;

   logic [COEFF_UPSHIFT:0]        head;
   logic                          fits;
   logic                          wr_acc;
   logic                          wr_ok;
   logic                          wr_bad;

   // Power-on tap set, index 0 = B1 ... 7 = B15.
   function automatic logic signed [COEFF_BITS-1:0] default_tap(input int unsigned k);
      case (k)
         0:       return COEFF_BITS'(-23);
         1:       return COEFF_BITS'(105);
         2:       return COEFF_BITS'(-263);
         3:       return COEFF_BITS'(526);
         4:       return COEFF_BITS'(-949);
         5:       return COEFF_BITS'(1672);
         6:       return COEFF_BITS'(-3216);
         7:       return COEFF_BITS'(10342);
         default: return '0;
      endcase
   endfunction

   // The sign bit and the bits shifted out by the upshift must all agree,
   // otherwise the shifted value would wrap on the DSP port.
   assign head   = wr_data_i[COEFF_BITS-1 -: COEFF_UPSHIFT+1];
   assign fits   = (&head) | ~(|head);
   assign wr_acc = wr_valid_i & wr_ready_o;
   assign wr_ok  = wr_acc & fits;
   assign wr_bad = wr_acc & ~fits;

   // State and flush counter registers; reset lands in FLUSH so the filter
   // sees a full flush after power-up.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FLUSH;
         cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: commits are only honoured in IDLE with pending data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (commit_i && (dirty_q || wr_ok)) begin
               state_d = SWAP;
            end
         end
         SWAP: begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered control outputs, decoded from the upcoming state so they
   // line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ready_o  <= 1'b1;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         filt_rst_o  <= 1'b1;
         out_valid_o <= 1'b0;
      end else begin
         wr_ready_o  <= (state_d == IDLE);
         busy_o      <= (state_d != IDLE);
         done_o      <= (state_q == FLUSH) && (state_d == IDLE);
         filt_rst_o  <= (state_d != IDLE);
         out_valid_o <= (state_d == IDLE);
      end
   end

   // Shadow bank, dirty flag and sticky overflow error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            shadow_q[k] <= default_tap(k);
         end
         dirty_q <= 1'b0;
         err_o   <= 1'b0;
      end else if (state_q == SWAP) begin
         dirty_q <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         if (wr_ok) begin
            shadow_q[wr_addr_i] <= wr_data_i;
            dirty_q             <= 1'b1;
         end
         if (wr_bad) begin
            err_o <= 1'b1;
         end
      end
   end

   // Live bank: the upshifted copy on the DSP bus changes only on the SWAP edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            coeff_o[k*COEFF_BITS +: COEFF_BITS] <= default_tap(k) << COEFF_UPSHIFT;
         end
      end else if (state_q == SWAP) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            coeff_o[k*COEFF_BITS +: COEFF_BITS] <= shadow_q[k] << COEFF_UPSHIFT;
         end
      end
   end

endmodule

// File: tb/tb_lpfull_coeff_sequencer.sv
// Self-checking bench for lpfull_coeff_sequencer: scenario tasks compare the
// DUT against a bank-level model (arrays of raw taps, dirty and error flags).
module tb_lpfull_coeff_sequencer;

   localparam int NT = 8;
   localparam int CB = 18;
   localparam int SH = 3;
   localparam int FL = 12;

   logic              clk_i      = 1'b0;
   logic              rst_ni     = 1'b0;
   logic              wr_valid_i = 1'b0;
   logic              commit_i   = 1'b0;
   logic [2:0]        wr_addr_i  = '0;
   logic [CB-1:0]     wr_data_i  = '0;
   logic              wr_ready_o, busy_o, done_o, err_o, filt_rst_o, out_valid_o;
   logic [NT*CB-1:0]  coeff_o;

   int total = 0;
   int bad   = 0;

   lpfull_coeff_sequencer #(
      .NTAPS         (NT),
      .COEFF_BITS    (CB),
      .COEFF_UPSHIFT (SH),
      .FLUSH_CYCLES  (FL)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_valid_i  (wr_valid_i),
      .wr_ready_o  (wr_ready_o),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .commit_i    (commit_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .coeff_o     (coeff_o),
      .filt_rst_o  (filt_rst_o),
      .out_valid_o (out_valid_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   int DEF [NT] = '{-23, 105, -263, 526, -949, 1672, -3216, 10342};
   int m_shadow [NT];
   int m_live   [NT];
   bit m_dirty;
   bit m_err;

   function automatic void m_reset();
      for (int i = 0; i < NT; i++) begin
         m_shadow[i] = DEF[i];
         m_live[i]   = DEF[i];
      end
      m_dirty = 1'b0;
      m_err   = 1'b0;
   endfunction

   // A raw value survives a x8 upshift in 18 signed bits iff it fits in 15.
   function automatic void m_write(input int a, input int v);
      if (v >= -16384 && v <= 16383) begin
         m_shadow[a] = v;
         m_dirty     = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endfunction

   function automatic bit m_commit();
      if (!m_dirty) return 1'b0;
      for (int i = 0; i < NT; i++) m_live[i] = m_shadow[i];
      m_dirty = 1'b0;
      m_err   = 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NT*CB-1:0] m_coeff();
      logic [NT*CB-1:0] r;
      for (int k = 0; k < NT; k++) r[k*CB +: CB] = CB'(m_live[k] * 8);
      return r;
   endfunction

   function automatic int tap(input logic [NT*CB-1:0] c, input int k);
      logic signed [CB-1:0] t;
      t = c[k*CB +: CB];
      return int'(t);
   endfunction

   // ---------------- observation helpers ----------------
   bit               rec_busy  [64];
   bit               rec_done  [64];
   bit               rec_valid [64];
   bit               rec_frst  [64];
   bit               rec_err   [64];
   logic [NT*CB-1:0] rec_coeff [64];

   // Records n cycles; index 0 is the cycle in which the caller drove commit.
   task automatic observe(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         rec_busy[i]  = busy_o;
         rec_done[i]  = done_o;
         rec_valid[i] = out_valid_o;
         rec_frst[i]  = filt_rst_o;
         rec_err[i]   = err_o;
         rec_coeff[i] = coeff_o;
         @(posedge clk_i); #1;
         commit_i   = 1'b0;
         wr_valid_i = 1'b0;
      end
   endtask

   function automatic int n_busy(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(rec_busy[i]);
      return s;
   endfunction

   function automatic int n_done(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(rec_done[i]);
      return s;
   endfunction

   function automatic int n_frst(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(rec_frst[i] && !rec_valid[i]);
      return s;
   endfunction

   // Drives one write and waits (bounded) for the handshake; waited=-1 on timeout.
   task automatic do_write(input int a, input int v, output int waited);
      bit r;
      wr_valid_i = 1'b1;
      wr_addr_i  = 3'(a);
      wr_data_i  = CB'(v);
      waited     = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         r = wr_ready_o;
         @(posedge clk_i); #1;
         if (r) begin
            waited = i;
            break;
         end
      end
      wr_valid_i = 1'b0;
      if (waited >= 0) m_write(a, v);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int hi = 0;
      rst_ni = 1'b0;
      m_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      total++;
      if ({wr_ready_o, busy_o, done_o, err_o, filt_rst_o, out_valid_o} !== 6'b100010) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 100010",
                  {wr_ready_o, busy_o, done_o, err_o, filt_rst_o, out_valid_o});
      end
      total++;
      if (coeff_o !== m_coeff()) begin
         bad++;
         $display("FAIL reset_coeff: got %h want %h", coeff_o, m_coeff());
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk_i);
         if (filt_rst_o && !out_valid_o) hi++;
         @(posedge clk_i); #1;
      end
      total++;
      if (hi != FL) begin
         bad++;
         $display("FAIL reset_flush_len: got %0d want %0d", hi, FL);
      end
      @(negedge clk_i);
      total++;
      if ({out_valid_o, done_o, filt_rst_o} !== 3'b110) begin
         bad++;
         $display("FAIL reset_release: got %b want 110", {out_valid_o, done_o, filt_rst_o});
      end
      total++;
      if (tap(coeff_o, 7) != 82736) begin
         bad++;
         $display("FAIL reset_tap7: got %0d want 82736", tap(coeff_o, 7));
      end
      total++;
      if (tap(coeff_o, 0) != -184) begin
         bad++;
         $display("FAIL reset_tap0: got %0d want -184", tap(coeff_o, 0));
      end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      total++;
      if (done_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_done_pulse: got %b want 0", done_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_single_write();
      int w;
      logic [NT*CB-1:0] old;
      do_write(2, -300, w);
      total++;
      if (w != 0) begin
         bad++;
         $display("FAIL sw_accept: got %0d want 0", w);
      end
      repeat (2) begin @(posedge clk_i); #1; end
      old = m_coeff();
      commit_i = 1'b1;
      void'(m_commit());
      observe(18);
      total++;
      if (n_busy(18) != 13 || !rec_busy[1] || rec_busy[14]) begin
         bad++;
         $display("FAIL sw_busy: got %0d cycles want 13 (idx 1..13)", n_busy(18));
      end
      total++;
      if (n_done(18) != 1 || !rec_done[14]) begin
         bad++;
         $display("FAIL sw_done: got %0d pulses want 1 at idx 14", n_done(18));
      end
      total++;
      if (n_frst(15) != 13 || !rec_valid[14]) begin
         bad++;
         $display("FAIL sw_blank: got %0d want 13", n_frst(15));
      end
      total++;
      if (rec_coeff[1] !== old) begin
         bad++;
         $display("FAIL sw_coeff_swap_cycle: got %h want %h", rec_coeff[1], old);
      end
      total++;
      if (rec_coeff[2] !== m_coeff()) begin
         bad++;
         $display("FAIL sw_coeff_after: got %h want %h", rec_coeff[2], m_coeff());
      end
      total++;
      if (tap(rec_coeff[2], 2) != -2400) begin
         bad++;
         $display("FAIL sw_tap2: got %0d want -2400", tap(rec_coeff[2], 2));
      end
   endtask

   task automatic test_overflow();
      int w;
      do_write(5, 40000, w);
      @(negedge clk_i);
      total++;
      if (err_o !== 1'b1) begin
         bad++;
         $display("FAIL ov_err_set: got %b want 1", err_o);
      end
      @(posedge clk_i); #1;
      commit_i = 1'b1;
      void'(m_commit());
      observe(16);
      total++;
      if (n_busy(16) != 0) begin
         bad++;
         $display("FAIL ov_commit_ignored: got %0d busy want 0", n_busy(16));
      end
      do_write(6, 16384, w);
      do_write(1, -16384, w);
      do_write(4, 16383, w);
      do_write(5, 2000, w);
      commit_i = 1'b1;
      void'(m_commit());
      observe(18);
      total++;
      if (rec_err[1] !== 1'b1 || rec_err[2] !== 1'b0) begin
         bad++;
         $display("FAIL ov_err_clear: got %b%b want 10", rec_err[1], rec_err[2]);
      end
      total++;
      if (tap(rec_coeff[17], 5) != 16000) begin
         bad++;
         $display("FAIL ov_tap5: got %0d want 16000", tap(rec_coeff[17], 5));
      end
      total++;
      if (tap(rec_coeff[17], 1) != -131072) begin
         bad++;
         $display("FAIL ov_tap1_edge: got %0d want -131072", tap(rec_coeff[17], 1));
      end
      total++;
      if (rec_coeff[17] !== m_coeff()) begin
         bad++;
         $display("FAIL ov_coeff: got %h want %h", rec_coeff[17], m_coeff());
      end
   endtask

   task automatic test_same_cycle();
      wr_valid_i = 1'b1;
      wr_addr_i  = 3'd0;
      wr_data_i  = CB'(50);
      commit_i   = 1'b1;
      m_write(0, 50);
      void'(m_commit());
      observe(18);
      total++;
      if (n_busy(18) != 13) begin
         bad++;
         $display("FAIL sc_busy: got %0d want 13", n_busy(18));
      end
      total++;
      if (tap(rec_coeff[17], 0) != 400) begin
         bad++;
         $display("FAIL sc_tap0: got %0d want 400", tap(rec_coeff[17], 0));
      end
   endtask

   task automatic test_ignored_commit();
      commit_i = 1'b1;
      void'(m_commit());
      observe(16);
      total++;
      if (n_busy(16) != 0 || n_done(16) != 0) begin
         bad++;
         $display("FAIL ic_idle: got busy=%0d done=%0d want 0/0", n_busy(16), n_done(16));
      end
      total++;
      if (rec_coeff[15] !== m_coeff()) begin
         bad++;
         $display("FAIL ic_coeff: got %h want %h", rec_coeff[15], m_coeff());
      end
   endtask

   task automatic test_back_to_back();
      int w;
      int v1, v2;
      int nb  = 0;
      int nd  = 0;
      int acc = -1;
      v1 = int'($urandom_range(20000)) - 10000;
      v2 = int'($urandom_range(20000)) - 10000;
      do_write(7, v1, w);
      commit_i = 1'b1;
      void'(m_commit());
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         nb += int'(busy_o);
         nd += int'(done_o);
         if (wr_valid_i && wr_ready_o && acc < 0) begin
            acc = i;
            m_write(3, v2);
         end
         @(posedge clk_i); #1;
         commit_i = (i + 1 == 5);
         if (i + 1 == 3) begin
            wr_valid_i = 1'b1;
            wr_addr_i  = 3'd3;
            wr_data_i  = CB'(v2);
         end
         if (acc >= 0) wr_valid_i = 1'b0;
      end
      total++;
      if (nb != 13 || nd != 1) begin
         bad++;
         $display("FAIL bb_one_swap: got busy=%0d done=%0d want 13/1", nb, nd);
      end
      total++;
      if (acc != 14) begin
         bad++;
         $display("FAIL bb_held_write: got idx %0d want 14", acc);
      end
      total++;
      if (coeff_o !== m_coeff()) begin
         bad++;
         $display("FAIL bb_no_apply: got %h want %h", coeff_o, m_coeff());
      end
      commit_i = 1'b1;
      void'(m_commit());
      observe(18);
      total++;
      if (rec_coeff[17] !== m_coeff() || n_busy(18) != 13) begin
         bad++;
         $display("FAIL bb_apply: got %h want %h", rec_coeff[17], m_coeff());
      end
   endtask

   task automatic test_random();
      int w, a, v, nw;
      bit taken;
      for (int it = 0; it < 6; it++) begin
         nw = int'($urandom_range(3, 1));
         for (int j = 0; j < nw; j++) begin
            a = int'($urandom_range(NT - 1));
            v = int'($urandom_range(60000)) - 30000;
            do_write(a, v, w);
            total++;
            if (w != 0) begin
               bad++;
               $display("FAIL rnd_accept: got %0d want 0", w);
            end
         end
         @(negedge clk_i);
         total++;
         if (err_o !== m_err) begin
            bad++;
            $display("FAIL rnd_err: got %b want %b", err_o, m_err);
         end
         @(posedge clk_i); #1;
         commit_i = 1'b1;
         taken = m_commit();
         observe(18);
         total++;
         if (n_busy(18) != (taken ? 13 : 0)) begin
            bad++;
            $display("FAIL rnd_busy: got %0d want %0d", n_busy(18), taken ? 13 : 0);
         end
         total++;
         if (rec_coeff[17] !== m_coeff()) begin
            bad++;
            $display("FAIL rnd_coeff: got %h want %h", rec_coeff[17], m_coeff());
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      int w;
      do_write(3, 999, w);
      commit_i = 1'b1;
      void'(m_commit());
      observe(7);
      #2;
      rst_ni = 1'b0;
      m_reset();
      #1;
      total++;
      if (tap(coeff_o, 3) != 4208 || coeff_o !== m_coeff()) begin
         bad++;
         $display("FAIL rm_coeff: got tap3=%0d want 4208", tap(coeff_o, 3));
      end
      total++;
      if ({filt_rst_o, out_valid_o, busy_o, wr_ready_o} !== 4'b1001) begin
         bad++;
         $display("FAIL rm_ctrl: got %b want 1001", {filt_rst_o, out_valid_o, busy_o, wr_ready_o});
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (FL) begin @(posedge clk_i); #1; end
      @(negedge clk_i);
      total++;
      if ({out_valid_o, done_o} !== 2'b11) begin
         bad++;
         $display("FAIL rm_recover: got %b want 11", {out_valid_o, done_o});
      end
      @(posedge clk_i); #1;
      commit_i = 1'b1;
      void'(m_commit());
      observe(16);
      total++;
      if (n_busy(16) != 0 || n_done(16) != 0) begin
         bad++;
         $display("FAIL rm_dirty_lost: got busy=%0d done=%0d want 0/0", n_busy(16), n_done(16));
      end
      total++;
      if (rec_coeff[15] !== m_coeff()) begin
         bad++;
         $display("FAIL rm_coeff_after: got %h want %h", rec_coeff[15], m_coeff());
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_overflow();
      test_same_cycle();
      test_ignored_commit();
      test_back_to_back();
      test_random();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
